irr_priority_unit: RTL
======================

IRR_PRIORITY_UNIT -- requirements
Module: irr_priority_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ir, input, 8, raw interrupt request lines IR0..IR7, asynchronous to clk.
REQ-004 SHALL have port ltim, input, 1, trigger mode: 1 = level, 0 = edge.
REQ-005 SHALL have port imr, input, 8, interrupt mask; bit n = 1 masks IRn.
REQ-006 SHALL have port isr, input, 8, in-service bits fed back from the downstream ISR stage.
REQ-007 SHALL have port ack, input, 1, single-cycle pulse marking the first interrupt acknowledge.
REQ-008 SHALL have port irr, output, 8, the interrupt request register, fed to the downstream ISR stage.
REQ-009 SHALL have port int_req, output, 1, the interrupt request to the CPU.
REQ-010 SHALL have port ack_vec, output, 8, the one-hot acknowledged level, valid when ack_valid = 1.
REQ-011 SHALL have port ack_valid, output, 1, a one-cycle strobe qualifying ack_vec.

Function
REQ-012 SHALL synchronise ir through two flops per bit (sync latency 2 cycles); all later logic uses the synchronised value ir_s.
REQ-013 Level mode SHALL make irr[n] follow ir_s[n] with 1 cycle of latency.
REQ-014 Edge mode SHALL set irr[n] on a 0->1 transition of ir_s[n], and SHALL clear it when ir_s[n] goes low or when IRn is acknowledged.
REQ-015 SHALL use fixed priority with IR0 highest, unless REQ-027 applies.
REQ-016 The candidate SHALL be the highest-priority n with irr[n] = 1 and imr[n] = 0, whose priority is above every set isr bit.
REQ-017 SHALL implement an FSM with states IDLE, PEND and ACKD.
- IDLE -> PEND: when a candidate exists.
- PEND -> IDLE: when the candidate disappears before ack; int_req drops the next cycle.
- PEND -> ACKD: on ack.
- ACKD -> IDLE: unconditionally after 1 cycle.
REQ-018 int_req SHALL be registered, and SHALL be 1 exactly while the state is PEND.
REQ-019 On ack in PEND, SHALL register the candidate's one-hot into ack_vec and pulse ack_valid for 1 cycle, in the cycle after ack.
REQ-020 On ack with no candidate (request withdrawn the same cycle, or the state is not PEND), SHALL return ack_vec = 8'h80 with ack_valid = 1 (spurious IR7).
REQ-021 The acknowledged irr bit SHALL clear in edge mode in the ACKD cycle; it SHALL re-set only on a new rising edge.
REQ-022 A rising edge arriving on the same bit as its clear SHALL lose; the request is dropped.
REQ-023 imr and isr changes SHALL take effect on the candidate combinationally, and on int_req in the next cycle.

Reset
REQ-024 rst_n low SHALL asynchronously clear the synchronisers, irr, int_req, ack_vec and ack_valid to 0, and set the FSM to IDLE.
REQ-025 Reset asserted mid-PEND or mid-ACKD SHALL abort the operation, with no ack_valid pulse.
REQ-026 After deassertion, a level already high in edge mode SHALL NOT register until it goes low and then rises again.

Configuration
REQ-027 With macro IRR_ROTATE_PRIO_EN defined, a 3-bit rotation pointer (reset 7) SHALL load the acknowledged level on each valid (non-spurious) ack; priority then starts at pointer+1 (mod 8), so the serviced level becomes lowest.
REQ-028 Without IRR_ROTATE_PRIO_EN, no pointer register SHALL exist, and priority SHALL stay fixed with IR0 highest.

Verification
REQ-029 Edge mode, imr = 0, isr = 0: raise ir[3]. Required: irr = 8'h08 after 3 cycles and int_req = 1 on the next cycle; an ack pulse gives ack_vec = 8'h08 with ack_valid = 1, and irr = 0.
REQ-030 ir = 8'h0A, imr = 8'h02. Required: ack gives ack_vec = 8'h08; with imr = 0 instead, ack gives ack_vec = 8'h02.
REQ-031 Level mode, ir[5] high, isr = 8'h04. Required: int_req = 0. Clear isr to 0: int_req = 1 next cycle.
REQ-032 Raise ir[6] until int_req = 1, then drop ir[6] and pulse ack. Required: ack_vec = 8'h80, ack_valid = 1.
REQ-033 Pull rst_n low while in PEND. Required: all outputs 0 immediately; no ack_valid follows.
REQ-034 With IRR_ROTATE_PRIO_EN: ack IR2, then request ir = 8'h06. Required: the next ack gives ack_vec = 8'h02 (IR2 is now lowest).

Source files
------------

// File: rtl/irr_priority_unit.sv
// Interrupt request register with synchronisers, priority resolver and acknowledge FSM.
// Optional rotating priority is enabled by defining IRR_ROTATE_PRIO_EN.
module irr_priority_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    input  logic       ack,
    output logic [7:0] irr,
    output logic       int_req,
    output logic [7:0] ack_vec,
    output logic       ack_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACKD = 2'd2
    } state_t;

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_prev;
    logic [1:0] r_fill;
    logic [7:0] r_irr;
    state_t     r_state;
    logic       r_int_req;
    logic [7:0] r_ack_vec;
    logic       r_ack_valid;

    state_t     w_state_next;
    logic [7:0] w_irr_next;
    logic [7:0] w_rise;
    logic [7:0] w_clr;
    logic [7:0] w_req;
    logic [2:0] w_base;
    logic       w_sync_valid;
    logic       w_cand_found;
    logic [2:0] w_cand_idx;
    logic [7:0] w_cand_onehot;
    logic       w_ack_hit;

    // Scan from the highest-priority slot; an in-service level at or above a request blocks it.
    function automatic logic [3:0] find_candidate(input logic [7:0] req,
                                                  input logic [7:0] svc,
                                                  input logic [2:0] base);
        logic       done;
        logic       found;
        logic [2:0] sel;
        logic [2:0] idx;
        done  = 1'b0;
        found = 1'b0;
        sel   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (done) begin
                done = 1'b1;
            end else if (svc[idx]) begin
                done = 1'b1;
            end else if (req[idx]) begin
                done  = 1'b1;
                found = 1'b1;
                sel   = idx;
            end else begin
                done = 1'b0;
            end
        end
        return {found, sel};
    endfunction

`ifdef IRR_ROTATE_PRIO_EN
    logic [2:0] r_ptr;

    // Rotation pointer remembers the last genuinely acknowledged level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd7;
        end else if (w_ack_hit) begin
            r_ptr <= w_cand_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_base = r_ptr + 3'd1;
`else
    assign w_base = 3'd0;
`endif

    assign w_sync_valid  = (r_fill == 2'd2);
    assign w_req         = r_irr & ~imr;
    assign {w_cand_found, w_cand_idx} = find_candidate(w_req, isr, w_base);
    assign w_cand_onehot = w_cand_found ? (8'd1 << w_cand_idx) : 8'd0;
    assign w_ack_hit     = ack && (r_state == ST_PEND) && w_cand_found;

    // Two-flop synchroniser plus fill counter that gates edge detection after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
            r_fill  <= 2'd0;
        end else begin
            r_sync1 <= ir;
            r_sync2 <= r_sync1;
            r_fill  <= w_sync_valid ? r_fill : (r_fill + 2'd1);
        end
    end

    // Previous-sample register starts all-ones so a line already high at reset needs a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 8'hFF;
        end else if (w_sync_valid) begin
            r_prev <= r_sync2;
        end else begin
            r_prev <= r_prev;
        end
    end

    // Request register next value; an acknowledge clear beats a simultaneous rising edge.
    always_comb begin
        w_rise = r_sync2 & ~r_prev;
        w_clr  = 8'h00;
        if (w_ack_hit && !ltim) begin
            w_clr = w_cand_onehot;
        end else begin
            w_clr = 8'h00;
        end
        if (ltim) begin
            w_irr_next = r_sync2;
        end else begin
            w_irr_next = (w_rise | (r_irr & r_sync2)) & ~w_clr;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_found) begin
                    w_state_next = ST_PEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (ack) begin
                    w_state_next = ST_ACKD;
                end else if (!w_cand_found) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_PEND;
                end
            end
            ST_ACKD: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, request register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_irr       <= 8'h00;
            r_int_req   <= 1'b0;
            r_ack_vec   <= 8'h00;
            r_ack_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_irr       <= w_irr_next;
            r_int_req   <= (w_state_next == ST_PEND);
            r_ack_valid <= ack;
            if (ack) begin
                r_ack_vec <= w_ack_hit ? w_cand_onehot : 8'h80;
            end else begin
                r_ack_vec <= 8'h00;
            end
        end
    end

    assign irr       = r_irr;
    assign int_req   = r_int_req;
    assign ack_vec   = r_ack_vec;
    assign ack_valid = r_ack_valid;

endmodule
